// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared constants and the per-output state encoding used by
//                the switch allocator and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  // A route_dest value of zero means "no valid destination".
  localparam int DEST_NONE  = 0;

  // Port numbering of the router.
  localparam int PORT_X     = 0;
  localparam int PORT_Y     = 1;
  localparam int PORT_LOCAL = 2;

  // Each output is either free or locked to one input for a whole packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_e;

endpackage : router_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first set
//                request at or after ptr_i, wrapping from NUM_PORTS-1 to 0.
//                Grant is one-hot, or all-zero when nothing is requested.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  // Rotate right so the pointer position lands on bit 0.
  function automatic logic [NUM_PORTS-1:0] rot_right(
    input logic [NUM_PORTS-1:0] v,
    input logic [PTR_W-1:0]     s
  );
    logic [2*NUM_PORTS-1:0] t;
    t = {v, v} >> s;
    return t[NUM_PORTS-1:0];
  endfunction

  // Rotate left, undoing rot_right.
  function automatic logic [NUM_PORTS-1:0] rot_left(
    input logic [NUM_PORTS-1:0] v,
    input logic [PTR_W-1:0]     s
  );
    logic [2*NUM_PORTS-1:0] t;
    t = {v, v} << s;
    return t[2*NUM_PORTS-1:NUM_PORTS];
  endfunction

  logic [NUM_PORTS-1:0] w_req_rot;
  logic [NUM_PORTS-1:0] w_gnt_rot;

  assign w_req_rot = rot_right(req_i, ptr_i);

  // Fixed priority on the rotated vector: lowest set bit wins.
  always_comb begin
    w_gnt_rot = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_gnt_rot = NUM_PORTS'(1) << k;
      end
    end
  end

  assign gnt_o = rot_left(w_gnt_rot, ptr_i);

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Per-output packet-lock switch allocator. Each output locks
//                to one input for a whole packet (head to tail), chosen by a
//                round-robin arbiter, and drives the crossbar select.
//                Optional lock watchdog enabled by SWITCH_ALLOC_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int SEL_W     = $clog2(NUM_PORTS + 1),
  parameter int TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       route_valid,
  input  logic [NUM_PORTS*SEL_W-1:0] route_dest,
  input  logic [NUM_PORTS-1:0]       route_last,
  output logic [NUM_PORTS-1:0]       route_grant,
  output logic [NUM_PORTS*SEL_W-1:0] control,
  output logic [NUM_PORTS-1:0]       error,
  input  logic                       error_clear,
  output logic [NUM_PORTS-1:0]       timeout
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Per output, a one-hot vector marking its current owner (zero when idle).
  logic [NUM_PORTS-1:0] w_lock_oh [NUM_PORTS];
  // Inputs currently owning some output; they are the granted inputs.
  logic [NUM_PORTS-1:0] w_busy;
  logic [NUM_PORTS-1:0] w_bad_dest;
  logic [NUM_PORTS-1:0] error_q;
  logic [NUM_PORTS-1:0] error_d;

  // Gather ownership of every output into the per-input grant vector.
  always_comb begin
    w_busy = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_busy = w_busy | w_lock_oh[o];
    end
  end

  assign route_grant = w_busy;

  // Invalid destinations from inputs not already holding a lock are flagged;
  // an owner's destination is ignored until its packet completes.
  always_comb begin
    w_bad_dest = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_bad_dest[i] = route_valid[i] && !w_busy[i] &&
                      ((route_dest[i*SEL_W +: SEL_W] == SEL_W'(DEST_NONE)) ||
                       (route_dest[i*SEL_W +: SEL_W] >  SEL_W'(NUM_PORTS)));
    end
  end

  // A new error event wins over a simultaneous clear.
  assign error_d = (error_clear ? '0 : error_q) | w_bad_dest;

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= '0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    out_state_e           state_q, state_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     ptr_q,   ptr_d;
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_win;
    logic [PTR_W-1:0]     w_win_idx;
    logic [PTR_W-1:0]     w_ptr_next;
    logic                 w_own_valid;
    logic                 w_own_last;

    // Requests for this output from inputs that are not already locked elsewhere.
    always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req[i] = route_valid[i] && !w_busy[i] &&
                   (route_dest[i*SEL_W +: SEL_W] == SEL_W'(o + 1));
      end
    end

    rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
    ) u_arb (
      .req_i (w_req),
      .ptr_i (ptr_q),
      .gnt_o (w_win)
    );

    // Convert the one-hot winner into an input index.
    always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_win[i]) begin
          w_win_idx = PTR_W'(i);
        end
      end
    end

    assign w_own_valid = route_valid[owner_q];
    assign w_own_last  = route_last[owner_q];
    assign w_ptr_next  = (owner_q == PTR_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

    assign w_lock_oh[o] = (state_q == LOCKED) ? (NUM_PORTS'(1) << owner_q) : '0;
    assign control[o*SEL_W +: SEL_W] =
        (state_q == LOCKED) ? (SEL_W'(owner_q) + SEL_W'(1)) : '0;

`ifdef SWITCH_ALLOC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q,  to_d;
`endif

    // Lock/release decision; a release always leaves one idle cycle.
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = to_q;
`endif
      case (state_q)
        IDLE: begin
`ifdef SWITCH_ALLOC_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (|w_req) begin
            state_d = LOCKED;
            owner_d = w_win_idx;
          end
        end
        LOCKED: begin
          if (w_own_valid && w_own_last) begin
            state_d = IDLE;
            ptr_d   = w_ptr_next;
          end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
          // Watchdog: consecutive owner-idle cycles force a release.
          if (w_own_valid) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ptr_d   = w_ptr_next;
            to_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    // Output state registers; reset drops every lock and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        cnt_q   <= '0;
        to_q    <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        cnt_q   <= cnt_d;
        to_q    <= to_d;
`endif
      end
    end

`ifdef SWITCH_ALLOC_TIMEOUT_EN
    assign timeout[o] = to_q;
`endif
  end : g_out

`ifndef SWITCH_ALLOC_TIMEOUT_EN
  assign timeout = '0;
`endif

endmodule : switch_allocator
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_allocator
//  Description : Directed self-checking bench for switch_allocator
//                (NUM_PORTS=3, SEL_W=2, TIMEOUT=16). Expected values follow
//                the SWITCH_ALLOC_TIMEOUT_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

  logic       clk;
  logic       rst_n;
  logic [2:0] route_valid;
  logic [5:0] route_dest;
  logic [2:0] route_last;
  logic [2:0] route_grant;
  logic [5:0] control;
  logic [2:0] error;
  logic       error_clear;
  logic [2:0] timeout;

  int n_checks;
  int n_errors;

  switch_allocator #(
    .NUM_PORTS (3),
    .SEL_W     (2),
    .TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .route_valid (route_valid),
    .route_dest  (route_dest),
    .route_last  (route_last),
    .route_grant (route_grant),
    .control     (control),
    .error       (error),
    .error_clear (error_clear),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    route_valid = '0;
    route_dest  = '0;
    route_last  = '0;
    error_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    route_valid = '0;
    route_dest  = '0;
    route_last  = '0;
    error_clear = 1'b0;
    #1;
    check("rst_control", 32'(control),     32'h0);
    check("rst_grant",   32'(route_grant), 32'h0);
    check("rst_error",   32'(error),       32'h0);
    check("rst_timeout", 32'(timeout),     32'h0);

    // Single flit: input 0 -> output 1 (dest 2).
    do_reset();
    route_valid = 3'b001; route_dest = 6'b000010; route_last = 3'b001;
    tick();
    check("single_ctrl", 32'(control),     32'h04);
    check("single_gnt",  32'(route_grant), 32'h1);
    tick();
    route_valid = '0; route_last = '0;
    check("single_rel_ctrl", 32'(control),     32'h0);
    check("single_rel_gnt",  32'(route_grant), 32'h0);

    // Contention: everyone to local, single-flit packets, held valid.
    do_reset();
    route_valid = 3'b111; route_dest = 6'b111111; route_last = 3'b111;
    begin
      logic [1:0] seq [7];
      seq = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1};
      for (int k = 0; k < 7; k++) begin
        tick();
        check($sformatf("rr_ctrl2_%0d", k), 32'(control[5:4]), 32'(seq[k]));
        if (k == 2) check("rr_gnt_in1", 32'(route_grant), 32'h2);
      end
    end
    route_valid = '0; route_last = '0;

    // Multi-flit hold: input 1 -> output 0 while input 2 waits for output 0.
    do_reset();
    route_valid = 3'b010; route_dest = 6'b000100; route_last = 3'b000;
    tick();
    check("mf_lock", 32'(control[1:0]), 32'h2);
    route_valid = 3'b110; route_dest = 6'b010100;     // flit 1
    tick();
    check("mf_f1", 32'(control[1:0]), 32'h2);
    route_valid = 3'b100;                             // gap
    tick();
    check("mf_gap1", 32'(control[1:0]), 32'h2);
    route_valid = 3'b110; route_dest = 6'b011100;     // flit 2, owner dest changes
    tick();
    check("mf_f2",      32'(control[1:0]), 32'h2);
    check("mf_ign_dst", 32'(control[5:4]), 32'h0);
    route_valid = 3'b100; route_dest = 6'b010100;     // gap
    tick();
    check("mf_gap2", 32'(control[1:0]), 32'h2);
    route_valid = 3'b110;                             // flit 3
    tick();
    check("mf_f3", 32'(control[1:0]), 32'h2);
    route_last = 3'b010;                              // flit 4 (tail)
    tick();
    check("mf_tail_idle", 32'(control[1:0]), 32'h0);
    route_valid = 3'b100; route_last = 3'b000;
    tick();
    check("mf_next_ctrl", 32'(control[1:0]), 32'h3);
    check("mf_next_gnt",  32'(route_grant),  32'h4);

    // Error: input 2 with dest 0.
    do_reset();
    route_valid = 3'b100; route_dest = 6'b000000;
    tick();
    check("err_set",  32'(error),       32'h4);
    check("err_gnt",  32'(route_grant), 32'h0);
    check("err_ctrl", 32'(control),     32'h0);
    route_valid = '0; error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("err_clr", 32'(error), 32'h0);
    route_valid = 3'b100; error_clear = 1'b1;
    tick();
    route_valid = '0; error_clear = 1'b0;
    check("err_clr_vs_set", 32'(error), 32'h4);

    // Reset mid-packet after the output-1 pointer has moved to 1.
    do_reset();
    route_valid = 3'b001; route_dest = 6'b000010; route_last = 3'b001;
    tick();
    tick();
    route_valid = '0; route_last = '0;
    tick();
    route_valid = 3'b010; route_dest = 6'b001000;
    tick();
    check("rmp_lock_ctrl", 32'(control),     32'h08);
    check("rmp_lock_gnt",  32'(route_grant), 32'h2);
    rst_n = 1'b0;
    #2;
    check("rmp_async_ctrl", 32'(control),     32'h0);
    check("rmp_async_gnt",  32'(route_grant), 32'h0);
    route_valid = 3'b011; route_dest = 6'b001010;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rmp_ptr0_ctrl", 32'(control),     32'h04);
    check("rmp_ptr0_gnt",  32'(route_grant), 32'h1);
    route_valid = '0;

    // Watchdog: owner stays silent while locked.
    do_reset();
    route_valid = 3'b001; route_dest = 6'b000010; route_last = 3'b000;
    tick();
    check("to_lock", 32'(control), 32'h04);
    route_valid = '0;
    repeat (15) tick();
    check("to_held15", 32'(control), 32'h04);
    check("to_flag15", 32'(timeout), 32'h0);
    tick();
`ifdef SWITCH_ALLOC_TIMEOUT_EN
    check("to_release", 32'(control),     32'h0);
    check("to_flag",    32'(timeout),     32'h2);
    check("to_gnt",     32'(route_grant), 32'h0);
`else
    check("to_release", 32'(control),     32'h04);
    check("to_flag",    32'(timeout),     32'h0);
    check("to_gnt",     32'(route_grant), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_switch_allocator
`default_nettype wire
